// File: rtl/demapper.sv
// demapper
// Receive-side C-PHY high-speed symbol demapper. One 7-symbol group, given as
// per-symbol Flip / Rotation / Polarity bits, is decoded back into the 16-bit
// word it carries. Flip patterns that carry no code are flagged. The decode is
// combinational and the word and flag are captured together in one register
// stage, so the latency is one clock and the throughput is one group per clock.
//
// Ports
//   clk              rising-edge clock
//   rst_n            synchronous active-low reset; clears the outputs
//   RxFlip[6:0]      flip bit of symbol k at bit k
//   RxRotation[6:0]  rotation bit of symbol k at bit k
//   RxPolarity[6:0]  polarity bit of symbol k at bit k
//   RxDataHS[15:0]   decoded word (0 when invalid)
//   RxInvalidCodeHS  high when the captured group had an illegal flip pattern
module demapper (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  RxFlip,
    input  logic [6:0]  RxRotation,
    input  logic [6:0]  RxPolarity,
    output logic [15:0] RxDataHS,
    output logic        RxInvalidCodeHS
);

    // Rotation/polarity pair per symbol, rotation as the MSB.
    logic [1:0] rp [7];

    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_rp
            assign rp[gi] = {RxRotation[gi], RxPolarity[gi]};
        end
    endgenerate

    logic [13:0] payload;
    logic [2:0]  flip_count;
    logic [2:0]  flip_pos;
    logic [3:0]  pair_code;
    logic        pair_ok;
    logic [15:0] data_next;
    logic        invalid_next;
    logic [15:0] data_reg;
    logic        invalid_reg;

    // Compact the pairs of the non-flipped symbols, highest symbol first.
    // Shifting left on each kept symbol leaves the payload right-aligned, so
    // with n flips the low 14-2n bits hold exactly the 7-n kept pairs.
    always_comb begin
        payload    = '0;
        flip_count = '0;
        flip_pos   = '0;
        for (int k = 6; k >= 0; k--) begin
            if (RxFlip[k]) begin
                flip_count = flip_count + 3'd1;
                flip_pos   = 3'(k);
            end else begin
                payload = {payload[11:0], rp[k]};
            end
        end
    end

    // Two-flip pattern to 4-bit code. The remaining five two-flip patterns
    // (0x28, 0x48, 0x30, 0x50, 0x60) have no code.
    always_comb begin
        pair_code = 4'h0;
        pair_ok   = 1'b1;
        case (RxFlip)
            7'h03: pair_code = 4'h0;
            7'h05: pair_code = 4'h1;
            7'h06: pair_code = 4'h2;
            7'h0A: pair_code = 4'h3;
            7'h12: pair_code = 4'h4;
            7'h22: pair_code = 4'h5;
            7'h42: pair_code = 4'h6;
            7'h09: pair_code = 4'h7;
            7'h11: pair_code = 4'h8;
            7'h21: pair_code = 4'h9;
            7'h41: pair_code = 4'hA;
            7'h0C: pair_code = 4'hB;
            7'h14: pair_code = 4'hC;
            7'h24: pair_code = 4'hD;
            7'h44: pair_code = 4'hE;
            7'h18: pair_code = 4'hF;
            default: pair_ok = 1'b0;
        endcase
    end

    always_comb begin
        data_next    = 16'h0000;
        invalid_next = 1'b0;
        case (flip_count)
            3'd0: data_next = {2'b00, payload};
            // Prefix k+4 lands in 4..A, keeping clear of the 0x0/0x3 and
            // 0xC..0xF prefixes used by the other paths.
            3'd1: data_next = {({1'b0, flip_pos} + 4'd4), payload[11:0]};
            3'd2: begin
                if (pair_ok) begin
                    data_next = {2'b11, pair_code, payload[9:0]};
                end else begin
                    invalid_next = 1'b1;
                end
            end
            default: invalid_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_reg    <= 16'h0000;
            invalid_reg <= 1'b0;
        end else begin
            data_reg    <= data_next;
            invalid_reg <= invalid_next;
        end
    end

    assign RxDataHS        = data_reg;
    assign RxInvalidCodeHS = invalid_reg;

endmodule

// File: tb/tb_demapper.sv
// Testbench for demapper. Stimulus is applied on the falling edge and the
// expected response is pushed into a scoreboard queue at the same time; a
// separate monitor pops one entry after every rising edge and compares it with
// the registered outputs. Directed vectors carry hand-computed constants;
// random vectors use a reference model built from the code rules.
module tb_demapper;

    logic        clk;
    logic        rst_n;
    logic [6:0]  RxFlip;
    logic [6:0]  RxRotation;
    logic [6:0]  RxPolarity;
    logic [15:0] RxDataHS;
    logic        RxInvalidCodeHS;

    demapper dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .RxFlip          (RxFlip),
        .RxRotation      (RxRotation),
        .RxPolarity      (RxPolarity),
        .RxDataHS        (RxDataHS),
        .RxInvalidCodeHS (RxInvalidCodeHS)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic        inv;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   txn    = 0;
    bit   stim_done = 0;

    // Reference model: the 16 legal two-flip patterns in code order.
    function automatic logic [16:0] model(input logic [6:0] f, input logic [6:0] r,
                                          input logic [6:0] p);
        logic [6:0] pats [16];
        int n;
        int payload;
        int pos;
        int code;
        pats = '{7'h03, 7'h05, 7'h06, 7'h0A, 7'h12, 7'h22, 7'h42, 7'h09,
                 7'h11, 7'h21, 7'h41, 7'h0C, 7'h14, 7'h24, 7'h44, 7'h18};
        n = $countones(f);
        payload = 0;
        pos = 0;
        for (int k = 6; k >= 0; k--) begin
            if (f[k]) pos = k;
            else payload = payload * 4 + 2 * int'(r[k]) + int'(p[k]);
        end
        if (n == 0) return {1'b0, 16'(payload)};
        if (n == 1) return {1'b0, 16'((pos + 4) * 4096 + payload)};
        if (n == 2) begin
            code = -1;
            for (int i = 0; i < 16; i++) if (pats[i] == f) code = i;
            if (code >= 0) return {1'b0, 16'(49152 + code * 1024 + payload)};
        end
        return {1'b1, 16'h0000};
    endfunction

    task automatic drive(input logic rst, input logic [6:0] f, input logic [6:0] r,
                         input logic [6:0] p);
        @(negedge clk);
        rst_n      = rst;
        RxFlip     = f;
        RxRotation = r;
        RxPolarity = p;
    endtask

    task automatic apply_const(input string name, input logic rst, input logic [6:0] f,
                               input logic [6:0] r, input logic [6:0] p,
                               input logic [15:0] d, input logic inv);
        exp_t e;
        drive(rst, f, r, p);
        e.data = d;
        e.inv  = inv;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic apply_model(input string name, input logic rst, input logic [6:0] f,
                               input logic [6:0] r, input logic [6:0] p);
        logic [16:0] m;
        m = rst ? model(f, r, p) : 17'h0;
        apply_const(name, rst, f, r, p, m[15:0], m[16]);
    endtask

    // Monitor: one comparison per rising edge that has a pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                txn++;
                if (RxDataHS === e.data && RxInvalidCodeHS === e.inv) begin
                    passes++;
                    $display("txn %0d %s ok data=%04h inv=%0b", txn, e.name, RxDataHS,
                             RxInvalidCodeHS);
                end else begin
                    $display("FAIL txn %0d %s: got data=%04h inv=%0b, expected data=%04h inv=%0b",
                             txn, e.name, RxDataHS, RxInvalidCodeHS, e.data, e.inv);
                end
            end
        end
    end

    initial begin
        logic [6:0] f;
        logic [6:0] r;
        logic [6:0] p;
        int cnt;
        rst_n      = 1'b0;
        RxFlip     = 7'h00;
        RxRotation = 7'h03;
        RxPolarity = 7'h03;

        // Directed vectors with hand-derived results.
        apply_const("reset",       1'b0, 7'h00, 7'h03, 7'h03, 16'h0000, 1'b0);
        apply_const("zero_flip",   1'b1, 7'h00, 7'h03, 7'h03, 16'h000F, 1'b0);
        apply_const("three_flip",  1'b1, 7'h51, 7'h7F, 7'h7F, 16'h0000, 1'b1);
        apply_const("pair_0a",     1'b1, 7'h0A, 7'h66, 7'h78, 16'hCFD8, 1'b0);
        apply_const("single_5",    1'b1, 7'h20, 7'h07, 7'h31, 16'h912B, 1'b0);
        apply_const("pair_42",     1'b1, 7'h42, 7'h06, 7'h65, 16'hD90D, 1'b0);
        apply_const("illegal_60",  1'b1, 7'h60, 7'h55, 7'h2A, 16'h0000, 1'b1);
        apply_const("mid_reset",   1'b0, 7'h0A, 7'h66, 7'h78, 16'h0000, 1'b0);
        apply_const("release",     1'b1, 7'h0A, 7'h66, 7'h78, 16'hCFD8, 1'b0);
        apply_const("all_ones_rp", 1'b1, 7'h00, 7'h7F, 7'h7F, 16'h3FFF, 1'b0);
        apply_const("single_0",    1'b1, 7'h01, 7'h7F, 7'h7F, 16'h4FFF, 1'b0);
        apply_const("single_6",    1'b1, 7'h40, 7'h00, 7'h00, 16'hA000, 1'b0);
        apply_const("pair_18",     1'b1, 7'h18, 7'h7F, 7'h7F, 16'hFFFF, 1'b0);
        apply_const("all_flip",    1'b1, 7'h7F, 7'h7F, 7'h7F, 16'h0000, 1'b1);

        // Every flip pattern with random RP pairs, covering all two-flip codes
        // and all illegal pairs.
        for (int i = 0; i < 128; i++) begin
            apply_model("sweep", 1'b1, 7'(i), 7'($urandom), 7'($urandom));
        end

        // Random groups biased toward 0..2 flips, with occasional resets.
        for (int i = 0; i < 250; i++) begin
            cnt = $urandom_range(0, 3);
            f = 7'h00;
            for (int j = 0; j < cnt; j++) f[$urandom_range(0, 6)] = 1'b1;
            r = 7'($urandom);
            p = 7'($urandom);
            apply_model("random", ($urandom_range(0, 19) != 0), f, r, p);
        end

        @(negedge clk);
        @(negedge clk);
        stim_done = 1;
    end

    // Bounded end of run: the scoreboard must drain within a few cycles.
    initial begin
        int budget;
        budget = 0;
        wait (stim_done);
        while (exp_q.size() > 0 && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
